// File: rtl/unity_decoder_pipe.sv
// unity_decoder_pipe: three-stage single-symbol-correcting decoder for the
// 80-bit Unity RS(10,8) codeword over GF(2^8), poly x^8+x^6+x^4+x^3+x^2+x+1.
// Stage A computes syndromes, stage B classifies the error, and stage C
// applies the correction. All stages advance together on one shared enable.
// Saturating RAS counters track corrected and uncorrectable deliveries.
module unity_decoder_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [79:0]      codeword_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      data_out,
    output logic [1:0]       status,
    output logic [3:0]       err_pos,
    output logic [CNT_W-1:0] ce_count,
    output logic [CNT_W-1:0] due_count,
    input  logic             cnt_clear
);

    // Parity-check columns for D0..D7, with D0 in the most significant byte.
    localparam logic [63:0] H1_VEC = 64'hE3B4E52A35389C7E;
    localparam logic [63:0] H2_VEC = 64'h24E230676D3C81A4;

    localparam logic [1:0] ST_CLEAN = 2'b00;
    localparam logic [1:0] ST_DATA  = 2'b01;
    localparam logic [1:0] ST_PAR   = 2'b10;
    localparam logic [1:0] ST_DUE   = 2'b11;

    // GF(2^8) multiply. Every call site has one constant operand, so each
    // call reduces to a fixed XOR network.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h00;
        p = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) r = r ^ p;
            p = {p[6:0], 1'b0} ^ (p[7] ? 8'h5F : 8'h00);
        end
        return r;
    endfunction

    // Inverse computed as a^254. It is only ever applied to constants.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int k = 1; k < 8; k++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    logic             adv;
    logic             a_vld_q;
    logic [7:0]       a_s1_q, a_s2_q;
    logic [63:0]      a_data_q;
    logic             b_vld_q;
    logic [1:0]       b_cls_q;
    logic [3:0]       b_pos_q;
    logic [7:0]       b_e_q;
    logic [63:0]      b_data_q;
    logic             out_valid_q;
    logic [63:0]      data_out_q;
    logic [1:0]       status_q;
    logic [3:0]       err_pos_q;
    logic [CNT_W-1:0] ce_count_q, due_count_q;

    logic [7:0]       s1_d, s2_d;
    logic [1:0]       cls_d;
    logic [3:0]       pos_d;
    logic [7:0]       e_d;
    logic [7:0]       match;
    logic [3:0]       hit_pos;
    logic [7:0]       hit_e;
    logic [63:0]      data_corr;
    logic             hs;

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv;
    assign hs       = out_valid_q && out_ready;

    // Syndromes of the incoming codeword.
    always_comb begin
        s1_d = codeword_in[15:8];
        s2_d = codeword_in[7:0];
        for (int i = 0; i < 8; i++) begin
            s1_d = s1_d ^ gf_mul(codeword_in[79-8*i -: 8], H1_VEC[63-8*i -: 8]);
            s2_d = s2_d ^ gf_mul(codeword_in[79-8*i -: 8], H2_VEC[63-8*i -: 8]);
        end
    end

    // Classify from the stage A syndromes. A data error at i gives S2 = S1*h1i.
    always_comb begin
        match   = 8'h00;
        hit_pos = 4'hF;
        hit_e   = 8'h00;
        cls_d   = ST_CLEAN;
        pos_d   = 4'hF;
        e_d     = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (gf_mul(a_s1_q, H1_VEC[63-8*i -: 8]) == a_s2_q) begin
                match[i] = 1'b1;
                hit_pos  = 4'(i);
                hit_e    = gf_mul(a_s1_q, gf_inv(H1_VEC[63-8*i -: 8]));
            end
        end
        if (a_s1_q == 8'h00 && a_s2_q == 8'h00) begin
            cls_d = ST_CLEAN;
        end else if (a_s2_q == 8'h00) begin
            cls_d = ST_PAR;
            pos_d = 4'd8;
        end else if (a_s1_q == 8'h00) begin
            cls_d = ST_PAR;
            pos_d = 4'd9;
        end else if (match != 8'h00 && (match & (match - 8'h01)) == 8'h00) begin
            cls_d = ST_DATA;
            pos_d = hit_pos;
            e_d   = hit_e;
        end else begin
            cls_d = ST_DUE;
        end
    end

    // Apply the error value to the located data symbol. DUE and parity-only
    // errors pass the data through untouched.
    always_comb begin
        data_corr = b_data_q;
        for (int i = 0; i < 8; i++) begin
            if (b_cls_q == ST_DATA && b_pos_q == 4'(i)) begin
                data_corr[63-8*i -: 8] = b_data_q[63-8*i -: 8] ^ b_e_q;
            end
        end
    end

    // Pipeline stages and counters. A stall freezes every stage at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_vld_q     <= 1'b0;
            a_s1_q      <= '0;
            a_s2_q      <= '0;
            a_data_q    <= '0;
            b_vld_q     <= 1'b0;
            b_cls_q     <= ST_CLEAN;
            b_pos_q     <= 4'hF;
            b_e_q       <= '0;
            b_data_q    <= '0;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            status_q    <= ST_CLEAN;
            err_pos_q   <= 4'hF;
            ce_count_q  <= '0;
            due_count_q <= '0;
        end else begin
            if (adv) begin
                a_vld_q     <= in_valid;
                if (in_valid) begin
                    a_s1_q   <= s1_d;
                    a_s2_q   <= s2_d;
                    a_data_q <= codeword_in[79:16];
                end
                b_vld_q     <= a_vld_q;
                if (a_vld_q) begin
                    b_cls_q  <= cls_d;
                    b_pos_q  <= pos_d;
                    b_e_q    <= e_d;
                    b_data_q <= a_data_q;
                end
                out_valid_q <= b_vld_q;
                if (b_vld_q) begin
                    data_out_q <= data_corr;
                    status_q   <= b_cls_q;
                    err_pos_q  <= b_pos_q;
                end
            end
            if (cnt_clear) begin
                ce_count_q  <= '0;
                due_count_q <= '0;
            end else if (hs) begin
                if ((status_q == ST_DATA || status_q == ST_PAR) && ce_count_q != '1)
                    ce_count_q <= ce_count_q + CNT_W'(1);
                if (status_q == ST_DUE && due_count_q != '1)
                    due_count_q <= due_count_q + CNT_W'(1);
            end
        end
    end

    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;
    assign status    = status_q;
    assign err_pos   = err_pos_q;
    assign ce_count  = ce_count_q;
    assign due_count = due_count_q;

endmodule

// File: tb/tb_unity_decoder_pipe.sv
// Scoreboard bench for unity_decoder_pipe with hand-computed codewords.
module tb_unity_decoder_pipe;

    localparam int TB_CNT_W = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [79:0]         codeword_in = '0;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [63:0]         data_out;
    logic [1:0]          status;
    logic [3:0]          err_pos;
    logic [TB_CNT_W-1:0] ce_count;
    logic [TB_CNT_W-1:0] due_count;
    logic                cnt_clear = 1'b0;

    unity_decoder_pipe #(.CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .codeword_in(codeword_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .status(status), .err_pos(err_pos),
        .ce_count(ce_count), .due_count(due_count), .cnt_clear(cnt_clear)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  st;
        logic [3:0]  pos;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    bit   lat_en = 1'b1;

    // Clean codewords: data symbols of 01 so parity is an XOR of H columns.
    localparam logic [79:0] C0 = {64'h00000000_00000000, 8'h00, 8'h00};
    localparam logic [79:0] C1 = {64'h00000001_00000000, 8'h2A, 8'h67};
    localparam logic [79:0] C2 = {64'h01000000_00000001, 8'h9D, 8'h80};
    localparam logic [79:0] C3 = {64'h00010100_00000000, 8'h51, 8'hD2};
    localparam logic [79:0] C4 = {64'h00000000_01010100, 8'h91, 8'hD0};
    localparam logic [79:0] C5 = {64'h02000000_00000000, 8'h99, 8'h48};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Monitor: pop and compare on every output handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_output: got data %h status %b pos %0d expected none",
                         data_out, status, err_pos);
            end else begin
                mon_e = sb.pop_front();
                chk("data_out", data_out, mon_e.data);
                chk("status", 64'(status), 64'(mon_e.st));
                chk("err_pos", 64'(err_pos), 64'(mon_e.pos));
                if (mon_e.lat) chk("latency", 64'(cyc - mon_e.acc), 64'd3);
            end
        end
    end

    task automatic send(input logic [79:0] cw, input logic [63:0] d,
                        input logic [1:0] st, input logic [3:0] pos);
        bit   got;
        exp_t e;
        got = 1'b0;
        in_valid = 1'b1;
        codeword_in = cw;
        for (int t = 0; t < 40 && !got; t++) begin
            @(negedge clk);
            if (in_ready) begin
                e.data = d; e.st = st; e.pos = pos; e.acc = cyc; e.lat = lat_en;
                sb.push_back(e);
                got = 1'b1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: got in_ready 0 expected 1 within 40 cycles");
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(posedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d outstanding expected 0", sb.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_data_out", data_out, 64'd0);
        chk("rst_status", 64'(status), 64'd0);
        chk("rst_err_pos", 64'(err_pos), 64'd15);
        chk("rst_ce", 64'(ce_count), 64'd0);
        chk("rst_due", 64'(due_count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // Clean back-to-back stream.
        send(C0, C0[79:16], 2'b00, 4'hF);
        send(C1, C1[79:16], 2'b00, 4'hF);
        send(C2, C2[79:16], 2'b00, 4'hF);
        send(C3, C3[79:16], 2'b00, 4'hF);
        send(C4, C4[79:16], 2'b00, 4'hF);
        send(C5, C5[79:16], 2'b00, 4'hF);
        drain();
        chk("clean_ce", 64'(ce_count), 64'd0);
        chk("clean_due", 64'(due_count), 64'd0);

        // Single-error and DUE patterns.
        send({64'h01000000_00000000, 8'h00, 8'h00}, 64'h0, 2'b01, 4'd0);
        send({64'h0, 8'h5A, 8'h00}, 64'h0, 2'b10, 4'd8);
        send({64'h0, 8'h00, 8'h5A}, 64'h0, 2'b10, 4'd9);
        send({64'h0, 8'h01, 8'h01}, 64'h0, 2'b11, 4'hF);
        send({64'h00000001_00800000, 8'h2A, 8'h67}, C1[79:16], 2'b01, 4'd5);
        send({64'h01000000_00000000, 8'h9D, 8'h80}, C2[79:16], 2'b01, 4'd7);
        send({C3[79:16], 8'h51, 8'hD3}, C3[79:16], 2'b10, 4'd9);
        send({C1[79:16], 8'h2B, 8'h66}, C1[79:16], 2'b11, 4'hF);
        send({64'hFD000000_00000000, 8'h99, 8'h48}, C5[79:16], 2'b01, 4'd0);
        drain();
        chk("err_ce", 64'(ce_count), 64'd7);
        chk("err_due", 64'(due_count), 64'd2);

        // Output stall with back-to-back input.
        lat_en = 1'b0;
        out_ready = 1'b0;
        fork
            begin
                send(C2, C2[79:16], 2'b00, 4'hF);
                send(C3, C3[79:16], 2'b00, 4'hF);
                send({64'h01000000_00000000, 8'h00, 8'h00}, 64'h0, 2'b01, 4'd0);
                send(C4, C4[79:16], 2'b00, 4'hF);
                send({64'h0, 8'h01, 8'h01}, 64'h0, 2'b11, 4'hF);
            end
            begin
                repeat (5) @(negedge clk);
                chk("stall_in_ready", 64'(in_ready), 64'd0);
                chk("stall_out_valid", 64'(out_valid), 64'd1);
                chk("stall_data_hold", data_out, C2[79:16]);
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain();
        chk("stall_ce", 64'(ce_count), 64'd8);
        chk("stall_due", 64'(due_count), 64'd3);

        // Clear, then saturate ce_count.
        cnt_clear = 1'b1;
        @(posedge clk); #1;
        cnt_clear = 1'b0;
        @(negedge clk);
        chk("clear_ce", 64'(ce_count), 64'd0);
        chk("clear_due", 64'(due_count), 64'd0);
        @(posedge clk); #1;
        lat_en = 1'b1;
        for (int k = 0; k < 15; k++)
            send({64'h01000000_00000000, 8'h00, 8'h00}, 64'h0, 2'b01, 4'd0);
        drain();
        chk("sat_ce_full", 64'(ce_count), 64'd15);
        send({64'h01000000_00000000, 8'h00, 8'h00}, 64'h0, 2'b01, 4'd0);
        drain();
        chk("sat_ce_hold", 64'(ce_count), 64'd15);

        // Clear coinciding with a correction handshake.
        lat_en = 1'b0;
        out_ready = 1'b0;
        send({64'h01000000_00000000, 8'h00, 8'h00}, 64'h0, 2'b01, 4'd0);
        for (int t = 0; t < 20 && !out_valid; t++) @(negedge clk);
        chk("clr_wait_valid", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        cnt_clear = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        cnt_clear = 1'b0;
        @(negedge clk);
        chk("clr_prio_ce", 64'(ce_count), 64'd0);
        @(posedge clk); #1;

        // Reset with two words in flight.
        send({64'h01000000_00000000, 8'h00, 8'h00}, 64'h0, 2'b01, 4'd0);
        send({64'h0, 8'h01, 8'h01}, 64'h0, 2'b11, 4'hF);
        rst = 1'b1;
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            chk("flush_out_valid", 64'(out_valid), 64'd0);
        end
        chk("flush_ce", 64'(ce_count), 64'd0);
        chk("flush_due", 64'(due_count), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
